axpy_chunk_sequencer: RTL and testbench
=======================================

# axpy_chunk_sequencer

Sequencer for the 8-lane complex vector-times-constant add/subtract datapath, which computes z = y ± (x·c) with conjugate-conjugate multiply and fixed pipeline latency. It streams a vector of `num_chunks` 8-element chunks through the datapath:

- reads x and y chunks from a shared vector memory;
- presents them as datapath operands;
- tracks in-flight chunks through the datapath pipeline;
- writes each result chunk back in order.

It replaces the datapath's free-running finish counter as the authority on when a vector operation is complete.

## Interface
Parameters:
- NI, 8, complex lanes per chunk
- ELEMENT_WIDTH, 64, bits per complex element
- ADDR_WIDTH, 10, chunk address width
- CNT_WIDTH, 10, chunk-count width
- LAT, 7, cycles from operands at dp_* ports to valid dp_result

Ports:
- clk  in  1  clock; reset reset, synchronous, active-high
- reset  in  1  synchronous active-high reset
- start  in  1  pulse; accepted only when idle
- op_in  in  1  0 = add, 1 = subtract; latched at start
- constant_in  in  ELEMENT_WIDTH  scalar c; latched at start
- x_base, y_base, z_base  in  ADDR_WIDTH  chunk base addresses; latched at start
- num_chunks  in  CNT_WIDTH  chunks to process; latched at start
- stall  in  1  memory arbitration backpressure; blocks new reads only
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- mem_rd_en  out  1  read strobe
- mem_rd_addr_x, mem_rd_addr_y  out  ADDR_WIDTH  read addresses
- mem_rd_data_x, mem_rd_data_y  in  ELEMENT_WIDTH*NI  read data, valid exactly 1 cycle after mem_rd_en
- dp_first_row, dp_second_row  out  ELEMENT_WIDTH*NI  registered datapath operands (x, y)
- dp_constant  out  ELEMENT_WIDTH  latched c
- dp_op  out  1  latched op
- dp_result  in  ELEMENT_WIDTH*NI  datapath result
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  ELEMENT_WIDTH*NI  write data

## Operation
- **States.** IDLE → ISSUE → DRAIN → DONE → IDLE.
- **IDLE.**
  - start=1 latches op_in, constant_in, the three bases and num_chunks.
  - Next state is ISSUE if num_chunks≠0, else DONE.
- **ISSUE.**
  - Issue counter i runs 0..num_chunks-1.
  - Each cycle with stall=0: mem_rd_en=1, mem_rd_addr_x=x_base+i, mem_rd_addr_y=y_base+i, i++.
  - With stall=1: mem_rd_en=0 and i holds.
  - After the last issue, go to DRAIN.
- **Operand stage.** One cycle after mem_rd_en, the read data is registered into dp_first_row / dp_second_row.
- **In-flight tracking.** A valid shift register of depth LAT+2 carries each issue. The tap at LAT+2 drives mem_wr_en, with mem_wr_data=dp_result.
- **Write address.** Write counter w starts at 0; mem_wr_addr=z_base+w; w increments per write. Writes occur in issue order, one per issued chunk, never dropped.
- **DRAIN.** Stay until w==num_chunks, then go to DONE.
- **DONE.** One cycle: done=1, busy=1. Next state is IDLE.
- **Latched values.** dp_op and dp_constant hold their latched values until the next accepted start.
- **Address arithmetic.** All address sums are modulo 2^ADDR_WIDTH and wrap silently.
- **Ignored start.** start outside IDLE, including in the DONE cycle, is ignored.
- **Stall scope.** stall never affects chunks already in flight. The datapath and writes continue regardless.
- **Reset.** Applies in any state, including mid-operation.
  - Returns to IDLE and clears the valid shift register and counters.
  - No mem_wr_en occurs after reset, even for chunks in flight.
  - Output reset values: busy=0, done=0, mem_rd_en=0, mem_wr_en=0; all addresses, dp_first_row, dp_second_row, dp_constant, dp_op and mem_wr_data are 0.

## Timing
- Cycle 0 = edge where start is sampled in IDLE.
- First possible mem_rd_en is cycle 1; busy=1 from cycle 1.
- Read at cycle t:
  - data arrives cycle t+1;
  - dp operands valid cycle t+2;
  - dp_result valid and mem_wr_en at cycle t+2+LAT (t+9 at LAT=7).
- Throughput: 1 chunk/cycle with no stall.
- No-stall completion, num_chunks=N: writes at cycles 10..N+9, done at cycle N+10, busy=0 at cycle N+11.
- num_chunks=0: done at cycle 1; no reads or writes.

## Test plan
Use a behavioural datapath model with latency LAT, and seeded memory.

1. **Reset values.** Assert reset for 3 cycles with random inputs → every output at its reset value; busy=0.
2. **Basic stream.** N=4, op=0, x_base=0, y_base=16, z_base=32, stall=0 →
   - mem_rd_en at cycles 1–4, addresses x 0..3 and y 16..19;
   - mem_wr_en at cycles 10–13, addresses 32..35, data = y+x·c;
   - done at cycle 14.
3. **Stall.** N=3, op=1, stall=1 in cycles 2–3 →
   - reads at cycles 1, 4, 5;
   - writes at cycles 10, 13, 14, data = y−x·c;
   - done at cycle 15.
4. **Zero length.** N=0 → done at cycle 1, busy=1 only in cycle 1, no mem_rd_en or mem_wr_en.
5. **Reset mid-operation.** Reset at cycle 6 of an N=8 run →
   - no mem_wr_en from cycle 6 on;
   - all outputs at reset values;
   - a following start with N=2 completes normally (done 12 cycles after its start).
6. **Ignored start and address wrap.** start pulsed during busy is ignored. z_base=1022, N=4 → writes to 1022, 1023, 0, 1; exactly 4 writes; one done pulse.

Source files
------------

// File: rtl/axpy_chunk_sequencer.sv
// Streams num_chunks x/y chunk pairs from vector memory through the complex axpy
// datapath and writes each result chunk back in issue order.
module axpy_chunk_sequencer #(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter int CNT_WIDTH     = 10,
  parameter int LAT           = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          op_in,
  input  logic [ELEMENT_WIDTH-1:0]      constant_in,
  input  logic [ADDR_WIDTH-1:0]         x_base,
  input  logic [ADDR_WIDTH-1:0]         y_base,
  input  logic [ADDR_WIDTH-1:0]         z_base,
  input  logic [CNT_WIDTH-1:0]          num_chunks,
  input  logic                          stall,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr_x,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr_y,
  input  logic [ELEMENT_WIDTH*NI-1:0]   mem_rd_data_x,
  input  logic [ELEMENT_WIDTH*NI-1:0]   mem_rd_data_y,
  output logic [ELEMENT_WIDTH*NI-1:0]   dp_first_row,
  output logic [ELEMENT_WIDTH*NI-1:0]   dp_second_row,
  output logic [ELEMENT_WIDTH-1:0]      dp_constant,
  output logic                          dp_op,
  input  logic [ELEMENT_WIDTH*NI-1:0]   dp_result,
  output logic                          mem_wr_en,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
  output logic [ELEMENT_WIDTH*NI-1:0]   mem_wr_data
);

  localparam int ROW_W = ELEMENT_WIDTH * NI;
  localparam int VLD_D = LAT + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     op_q;
  logic [ELEMENT_WIDTH-1:0] const_q;
  logic [ADDR_WIDTH-1:0]    xb_q;
  logic [ADDR_WIDTH-1:0]    yb_q;
  logic [ADDR_WIDTH-1:0]    zb_q;
  logic [CNT_WIDTH-1:0]     num_q;
  logic [CNT_WIDTH-1:0]     iss_q;
  logic [CNT_WIDTH-1:0]     iss_d;
  logic [CNT_WIDTH-1:0]     wr_q;
  logic [CNT_WIDTH-1:0]     wr_d;
  logic [VLD_D-1:0]         vld_q;
  logic [ROW_W-1:0]         x_p1_q;
  logic [ROW_W-1:0]         y_p1_q;
  logic                     rd_fire;
  logic                     wr_fire;

  // Reads stop the instant reset or stall is seen; writes only obey reset.
  assign rd_fire = (state_q == S_ISSUE) && !stall && !reset;
  assign wr_fire = vld_q[VLD_D-1] && !reset;

  always_comb begin
    iss_d = iss_q;
    wr_d  = wr_q;
    if (rd_fire) begin
      iss_d = iss_q + CNT_WIDTH'(1);
    end
    if (wr_fire) begin
      wr_d = wr_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= 1'b0;
      const_q <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      zb_q    <= '0;
      num_q   <= '0;
      iss_q   <= '0;
      wr_q    <= '0;
      vld_q   <= '0;
      x_p1_q  <= '0;
      y_p1_q  <= '0;
    end else begin
      // Stage p0 -> p1: read data lands one cycle after the strobe.
      vld_q <= {vld_q[VLD_D-2:0], rd_fire};
      if (vld_q[0]) begin
        x_p1_q <= mem_rd_data_x;
        y_p1_q <= mem_rd_data_y;
      end
      iss_q  <= iss_d;
      wr_q   <= wr_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_in;
            const_q <= constant_in;
            xb_q    <= x_base;
            yb_q    <= y_base;
            zb_q    <= z_base;
            num_q   <= num_chunks;
            iss_q   <= '0;
            wr_q    <= '0;
            busy_q  <= 1'b1;
            if (num_chunks != '0) begin
              state_q <= S_ISSUE;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (rd_fire && (iss_q == num_q - CNT_WIDTH'(1))) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave on the cycle of the final write so done follows it directly.
          if (wr_d == num_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_rd_en     = rd_fire;
  assign mem_rd_addr_x = xb_q + ADDR_WIDTH'(iss_q);
  assign mem_rd_addr_y = yb_q + ADDR_WIDTH'(iss_q);
  assign dp_first_row  = x_p1_q;
  assign dp_second_row = y_p1_q;
  assign dp_constant   = const_q;
  assign dp_op         = op_q;
  // Stage p1+LAT: datapath result is written back on the in-flight tap.
  assign mem_wr_en     = wr_fire;
  assign mem_wr_addr   = zb_q + ADDR_WIDTH'(wr_q);
  assign mem_wr_data   = wr_fire ? dp_result : '0;

endmodule

// File: tb/tb_axpy_chunk_sequencer.sv
// Bench for axpy_chunk_sequencer: seeded memory, behavioural datapath and a
// schedule-based reference for read/write/done timing and data.
module tb_axpy_chunk_sequencer;
  localparam int NI  = 8;
  localparam int EW  = 64;
  localparam int AW  = 10;
  localparam int CW  = 10;
  localparam int LAT = 7;
  localparam int LW  = EW * NI;

  logic          clk = 1'b0;
  logic          reset, start, op_in, stall;
  logic [EW-1:0] constant_in;
  logic [AW-1:0] x_base, y_base, z_base;
  logic [CW-1:0] num_chunks;
  logic          busy, done, mem_rd_en, mem_wr_en, dp_op;
  logic [AW-1:0] mem_rd_addr_x, mem_rd_addr_y, mem_wr_addr;
  logic [LW-1:0] mem_rd_data_x, mem_rd_data_y, dp_result;
  logic [LW-1:0] dp_first_row, dp_second_row, mem_wr_data;
  logic [EW-1:0] dp_constant;

  axpy_chunk_sequencer #(.NI(NI), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW),
                         .CNT_WIDTH(CW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in),
    .constant_in(constant_in), .x_base(x_base), .y_base(y_base),
    .z_base(z_base), .num_chunks(num_chunks), .stall(stall),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr_x(mem_rd_addr_x), .mem_rd_addr_y(mem_rd_addr_y),
    .mem_rd_data_x(mem_rd_data_x), .mem_rd_data_y(mem_rd_data_y),
    .dp_first_row(dp_first_row), .dp_second_row(dp_second_row),
    .dp_constant(dp_constant), .dp_op(dp_op), .dp_result(dp_result),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] mem  [0:1023];
  logic [LW-1:0] pipe [0:LAT-1];
  int  ec = 0;
  int  total = 0;
  int  bad = 0;
  bit  busy_h [0:8191];
  bit  stall_s [0:511];
  bit  spulse [0:511];
  int  rd_c[$];
  logic [AW-1:0] rd_ax[$], rd_ay[$];
  int  wr_c[$];
  logic [AW-1:0] wr_a[$];
  logic [LW-1:0] wr_d[$];
  int  done_c[$];

  function automatic logic [LW-1:0] rand_row();
    logic [LW-1:0] r;
    for (int j = 0; j < LW / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // z = y +/- conj(x) * conj(c), lane-wise on 32-bit re/im halves.
  function automatic logic [LW-1:0] axpy(input logic [LW-1:0] x, input logic [LW-1:0] y,
                                         input logic [EW-1:0] c, input bit sub);
    logic [LW-1:0] r;
    for (int l = 0; l < NI; l++) begin
      logic signed [31:0] xr, xi, yr, yi, cr, ci, pr, pi;
      xr = x[l*64 +: 32]; xi = x[l*64+32 +: 32];
      yr = y[l*64 +: 32]; yi = y[l*64+32 +: 32];
      cr = c[31:0];       ci = c[63:32];
      pr = xr * cr - xi * ci;
      pi = -(xr * ci + xi * cr);
      r[l*64 +: 32]    = sub ? yr - pr : yr + pr;
      r[l*64+32 +: 32] = sub ? yi - pi : yi + pi;
    end
    return r;
  endfunction

  // Memory read port (1-cycle) and a LAT-deep datapath model.
  always @(posedge clk) begin
    ec <= ec + 1;
    if (mem_rd_en === 1'b1) begin
      mem_rd_data_x <= mem[mem_rd_addr_x];
      mem_rd_data_y <= mem[mem_rd_addr_y];
    end else begin
      mem_rd_data_x <= rand_row();
      mem_rd_data_y <= rand_row();
    end
    pipe[0] <= axpy(dp_first_row, dp_second_row, dp_constant, dp_op);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_result = pipe[LAT-1];

  always @(negedge clk) begin
    if (ec < 8192) busy_h[ec] = busy;
    if (mem_rd_en === 1'b1) begin
      rd_c.push_back(ec); rd_ax.push_back(mem_rd_addr_x); rd_ay.push_back(mem_rd_addr_y);
    end
    if (mem_wr_en === 1'b1) begin
      wr_c.push_back(ec); wr_a.push_back(mem_wr_addr); wr_d.push_back(mem_wr_data);
    end
    if (done === 1'b1) done_c.push_back(ec);
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, " busy"}, LW'(busy), '0);
    chk({nm, " done"}, LW'(done), '0);
    chk({nm, " rd_en"}, LW'(mem_rd_en), '0);
    chk({nm, " wr_en"}, LW'(mem_wr_en), '0);
    chk({nm, " rd_ax"}, LW'(mem_rd_addr_x), '0);
    chk({nm, " rd_ay"}, LW'(mem_rd_addr_y), '0);
    chk({nm, " wr_addr"}, LW'(mem_wr_addr), '0);
    chk({nm, " row1"}, dp_first_row, '0);
    chk({nm, " row2"}, dp_second_row, '0);
    chk({nm, " const"}, LW'(dp_constant), '0);
    chk({nm, " op"}, LW'(dp_op), '0);
    chk({nm, " wr_data"}, mem_wr_data, '0);
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 512; k++) begin stall_s[k] = 1'b0; spulse[k] = 1'b0; end
  endtask

  task automatic scramble_inputs();
    op_in       = 1'($urandom);
    constant_in = {$urandom, $urandom};
    x_base      = AW'($urandom);
    y_base      = AW'($urandom);
    z_base      = AW'($urandom);
    num_chunks  = CW'($urandom_range(1, 9));
  endtask

  task automatic run_op(input string nm, input bit op, input logic [EW-1:0] c,
                        input logic [AW-1:0] xb, input logic [AW-1:0] yb,
                        input logic [AW-1:0] zb, input int n, input int win,
                        output int done_rel);
    int S, rb, wb, db, k, cnt, exp_done;
    int exp_rd[$];
    logic [AW-1:0] ax, ay, az;
    rb = rd_c.size(); wb = wr_c.size(); db = done_c.size();
    op_in = op; constant_in = c; x_base = xb; y_base = yb; z_base = zb;
    num_chunks = CW'(n); stall = stall_s[0]; start = 1'b1;
    @(posedge clk); #1;
    S = ec;
    for (int j = 1; j <= win; j++) begin
      stall = stall_s[j];
      start = spulse[j];
      scramble_inputs();
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0;
    k = 1; cnt = 0;
    while (cnt < n && k < 512) begin
      if (!stall_s[k]) begin exp_rd.push_back(k); cnt++; end
      k++;
    end
    exp_done = (n == 0) ? 1 : exp_rd[n-1] + LAT + 3;
    chk($sformatf("%s rd_count", nm), LW'(rd_c.size() - rb), LW'(n));
    for (int i = 0; i < n && rb + i < rd_c.size(); i++) begin
      ax = xb + AW'(i); ay = yb + AW'(i);
      chk($sformatf("%s rd_cyc%0d", nm, i), LW'(rd_c[rb+i] - S + 1), LW'(exp_rd[i]));
      chk($sformatf("%s rd_ax%0d", nm, i), LW'(rd_ax[rb+i]), LW'(ax));
      chk($sformatf("%s rd_ay%0d", nm, i), LW'(rd_ay[rb+i]), LW'(ay));
    end
    chk($sformatf("%s wr_count", nm), LW'(wr_c.size() - wb), LW'(n));
    for (int i = 0; i < n && wb + i < wr_c.size(); i++) begin
      ax = xb + AW'(i); ay = yb + AW'(i); az = zb + AW'(i);
      chk($sformatf("%s wr_cyc%0d", nm, i), LW'(wr_c[wb+i] - S + 1), LW'(exp_rd[i] + LAT + 2));
      chk($sformatf("%s wr_addr%0d", nm, i), LW'(wr_a[wb+i]), LW'(az));
      chk($sformatf("%s wr_data%0d", nm, i), wr_d[wb+i], axpy(mem[ax], mem[ay], c, op));
    end
    chk($sformatf("%s done_count", nm), LW'(done_c.size() - db), LW'(1));
    done_rel = (done_c.size() > db) ? done_c[db] - S + 1 : 0;
    chk($sformatf("%s done_cyc", nm), LW'(done_rel), LW'(exp_done));
    chk($sformatf("%s busy_c0", nm), LW'(busy_h[S-1]), LW'(0));
    chk($sformatf("%s busy_c1", nm), LW'(busy_h[S]), LW'(1));
    chk($sformatf("%s busy_done", nm), LW'(busy_h[S+exp_done-1]), LW'(1));
    chk($sformatf("%s busy_after", nm), LW'(busy_h[S+exp_done]), LW'(0));
  endtask

  initial begin
    int dr, S, wb, db, n;
    logic [EW-1:0] c;
    for (int a = 0; a < 1024; a++) mem[a] = rand_row();
    clear_sched();

    // Reset with random inputs, then released.
    reset = 1'b1; start = 1'($urandom); stall = 1'($urandom);
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_held");
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    check_reset("rst_rel");
    repeat (2) begin @(posedge clk); #1; end

    // Basic add stream.
    c = {$urandom, $urandom};
    run_op("basic", 1'b0, c, 10'd0, 10'd16, 10'd32, 4, 30, dr);
    chk("basic done14", LW'(dr), LW'(14));

    // Stall in cycles 2-3, subtract.
    clear_sched(); stall_s[2] = 1'b1; stall_s[3] = 1'b1;
    c = {$urandom, $urandom};
    run_op("stall", 1'b1, c, 10'd40, 10'd60, 10'd80, 3, 30, dr);
    chk("stall done15", LW'(dr), LW'(15));

    // Zero length.
    clear_sched();
    run_op("zero", 1'b0, {$urandom, $urandom}, 10'd5, 10'd6, 10'd7, 0, 20, dr);
    chk("zero done1", LW'(dr), LW'(1));

    // Reset at cycle 6 of an N=8 run.
    wb = wr_c.size(); db = done_c.size();
    op_in = 1'b1; constant_in = {$urandom, $urandom};
    x_base = 10'd100; y_base = 10'd200; z_base = 10'd300; num_chunks = 10'd8;
    stall = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    S = ec; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midrst busy_c6", LW'(busy), LW'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset("midrst");
    repeat (20) begin @(posedge clk); #1; end
    chk("midrst no_writes", LW'(wr_c.size() - wb), LW'(0));
    chk("midrst no_done", LW'(done_c.size() - db), LW'(0));
    chk("midrst idle_busy", LW'(busy_h[S+15]), LW'(0));
    clear_sched();
    run_op("post_rst", 1'b0, {$urandom, $urandom}, 10'd400, 10'd500, 10'd600, 2, 30, dr);
    chk("post_rst done12", LW'(dr), LW'(12));

    // Ignored start pulses (mid-run and in the done cycle) plus z wrap.
    clear_sched(); spulse[3] = 1'b1; spulse[14] = 1'b1;
    run_op("wrap", 1'b1, {$urandom, $urandom}, AW'($urandom), AW'($urandom),
           10'd1022, 4, 40, dr);
    chk("wrap done14", LW'(dr), LW'(14));
    chk("wrap last_addr", LW'(wr_a[wr_a.size()-1]), LW'(1));

    // Randomized runs with random stall patterns.
    for (int r = 0; r < 3; r++) begin
      clear_sched();
      for (int k = 1; k <= 40; k++) stall_s[k] = ($urandom_range(0, 99) < 30);
      n = $urandom_range(1, 12);
      run_op($sformatf("rand%0d", r), 1'($urandom), {$urandom, $urandom},
             AW'($urandom), AW'($urandom), AW'($urandom), n, 90, dr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
